// File: rtl/circle_plotter_pkg.sv
// circle_plotter_pkg
// Shared definitions for the circle plotter slice.
//   - DEFAULT_SCREEN_W / DEFAULT_SCREEN_H : default visible raster size (160x120)
//   - state_t                             : plotter FSM states
//   - clipCheck()                         : true when a signed pixel lies on screen
package circle_plotter_pkg;

  localparam int DEFAULT_SCREEN_W = 160;
  localparam int DEFAULT_SCREEN_H = 120;

  // The eight octant states are encoded consecutively, so the octant index
  // is simply the state value minus OCT0.
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CLEAR  = 4'd1,
    INIT   = 4'd2,
    OCT0   = 4'd3,
    OCT1   = 4'd4,
    OCT2   = 4'd5,
    OCT3   = 4'd6,
    OCT4   = 4'd7,
    OCT5   = 4'd8,
    OCT6   = 4'd9,
    OCT7   = 4'd10,
    UPDATE = 4'd11,
    DONE   = 4'd12
  } state_t;

  function automatic logic clipCheck(input int px, input int py, input int w, input int h);
    return (px >= 0) && (px < w) && (py >= 0) && (py < h);
  endfunction

endpackage

// File: rtl/circle_plotter_if.sv
// circle_plotter_if
// Request/response and pixel-port bundle between the key/switch decode logic,
// the circle plotter and the VGA adapter.
//   Requests  : start, clear, xc, yc, radius, colour_in
//   Status    : busy, done
//   Pixel port: x, y, colour, plot
// Modports: master drives requests and observes the rest; slave is the plotter.
interface circle_plotter_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3,
  parameter int RW = 7
);

  logic          start;
  logic          clear;
  logic [XW-1:0] xc;
  logic [YW-1:0] yc;
  logic [RW-1:0] radius;
  logic [CW-1:0] colour_in;
  logic          busy;
  logic          done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;

  modport master (
    output start, clear, xc, yc, radius, colour_in,
    input  busy, done, x, y, colour, plot
  );

  modport slave (
    input  start, clear, xc, yc, radius, colour_in,
    output busy, done, x, y, colour, plot
  );

endinterface

// File: rtl/circle_octant_gen.sv
// circle_octant_gen
// Combinational octant mapper: turns the centre and the current midpoint
// offsets (cx, cy) into one of the eight symmetric circle points and flags
// whether it lands on screen.
//   xc_i, yc_i  : circle centre (unsigned)
//   cx_i, cy_i  : midpoint offsets (unsigned)
//   octant_i    : 0..7, selects the symmetric point
//   px_o, py_o  : signed point, two bits wider than the screen coordinates
//   onScreen_o  : point is inside the visible raster
module circle_octant_gen
  import circle_plotter_pkg::*;
#(
  parameter int SCREEN_W = DEFAULT_SCREEN_W,
  parameter int SCREEN_H = DEFAULT_SCREEN_H,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int RW       = 7
) (
  input  logic [XW-1:0]        xc_i,
  input  logic [YW-1:0]        yc_i,
  input  logic [RW-1:0]        cx_i,
  input  logic [RW-1:0]        cy_i,
  input  logic [2:0]           octant_i,
  output logic signed [XW+1:0] px_o,
  output logic signed [YW+1:0] py_o,
  output logic                 onScreen_o
);

  logic [RW-1:0]        aSel;
  logic [RW-1:0]        bSel;
  logic signed [XW+1:0] xcS;
  logic signed [XW+1:0] aS;
  logic signed [YW+1:0] ycS;
  logic signed [YW+1:0] bS;

  // Octants 4..7 swap the roles of cx and cy; bit 0 negates the x offset
  // and bit 1 negates the y offset, which reproduces the fixed emission order.
  always_comb begin
    aSel       = octant_i[2] ? cy_i : cx_i;
    bSel       = octant_i[2] ? cx_i : cy_i;
    xcS        = $signed({2'b00, xc_i});
    ycS        = $signed({2'b00, yc_i});
    aS         = $signed({{(XW+2-RW){1'b0}}, aSel});
    bS         = $signed({{(YW+2-RW){1'b0}}, bSel});
    px_o       = octant_i[0] ? (xcS - aS) : (xcS + aS);
    py_o       = octant_i[1] ? (ycS - bS) : (ycS + bS);
    onScreen_o = clipCheck(int'(px_o), int'(py_o), SCREEN_W, SCREEN_H);
  end

endmodule

// File: rtl/circle_plotter.sv
// circle_plotter
// Midpoint circle rasteriser with a full-screen clear mode, feeding the VGA
// adapter pixel port at most one pixel per clock. All outputs are registered
// and reflect the current FSM state.
//   CLOCK_50 : system clock, rising edge
//   resetn   : synchronous, active-low reset
//   bus      : slave side of circle_plotter_if (start/clear/centre/radius/colour
//              in, busy/done and x/y/colour/plot out)
module circle_plotter
  import circle_plotter_pkg::*;
#(
  parameter int SCREEN_W     = DEFAULT_SCREEN_W,
  parameter int SCREEN_H     = DEFAULT_SCREEN_H,
  parameter int XW           = 8,
  parameter int YW           = 7,
  parameter int CW           = 3,
  parameter int RW           = 7,
  parameter int CLEAR_COLOUR = 0
) (
  input logic             CLOCK_50,
  input logic             resetn,
  circle_plotter_if.slave bus
);

  localparam int DW = RW + 4;
  localparam logic signed [DW-1:0] D_ONE   = DW'(1);
  localparam logic signed [DW-1:0] D_THREE = DW'(3);
  localparam logic signed [DW-1:0] D_SIX   = DW'(6);
  localparam logic signed [DW-1:0] D_TEN   = DW'(10);
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);

  state_t               state_q;
  logic [XW-1:0]        xc_q;
  logic [YW-1:0]        yc_q;
  logic [RW-1:0]        radius_q;
  logic [CW-1:0]        colourLatch_q;
  logic [RW-1:0]        cx_q;
  logic [RW-1:0]        cy_q;
  logic signed [DW-1:0] d_q;
  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic [CW-1:0]        colourOut_q;
  logic                 plot_q;
  logic                 busy_q;
  logic                 done_q;

  logic [RW-1:0]        cxNext_d;
  logic [RW-1:0]        cyNext_d;
  logic signed [DW-1:0] dNext_d;
  logic [2:0]           octNext_d;
  logic                 loopAgain_d;
  logic [3:0]           stateOffset;
  logic signed [DW-1:0] cxS, cyS, rS, cxNextS, cyNextS;
  logic signed [XW+1:0] pxGen;
  logic signed [YW+1:0] pyGen;
  logic                 onScreenGen;

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colourOut_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

  assign stateOffset = 4'(state_q) - 4'(OCT0);
  assign cxS         = $signed({{(DW-RW){1'b0}}, cx_q});
  assign cyS         = $signed({{(DW-RW){1'b0}}, cy_q});
  assign rS          = $signed({{(DW-RW){1'b0}}, radius_q});

  // The loop test runs on signed copies so that cy stepping below zero
  // (radius 0) ends the draw instead of wrapping around.
  assign cxNextS     = cxS + D_ONE;
  assign cyNextS     = d_q[DW-1] ? cyS : (cyS - D_ONE);
  assign loopAgain_d = (cyNextS >= cxNextS);

  // Values that cx/cy/d take after this cycle, plus the octant that the next
  // cycle will emit. Pixel outputs are registered, so the octant generator is
  // fed with the upcoming state's operands rather than the current ones.
  always_comb begin
    cxNext_d  = cx_q;
    cyNext_d  = cy_q;
    dNext_d   = d_q;
    octNext_d = 3'(stateOffset + 4'd1);
    case (state_q)
      INIT: begin
        cxNext_d  = '0;
        cyNext_d  = radius_q;
        dNext_d   = D_THREE - (rS <<< 1);
        octNext_d = 3'd0;
      end
      UPDATE: begin
        cxNext_d  = cxNextS[RW-1:0];
        cyNext_d  = cyNextS[RW-1:0];
        dNext_d   = d_q[DW-1] ? (d_q + (cxS <<< 2) + D_SIX)
                              : (d_q + ((cxS - cyS) <<< 2) + D_TEN);
        octNext_d = 3'd0;
      end
      default: ;
    endcase
  end

  circle_octant_gen #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .XW       (XW),
    .YW       (YW),
    .RW       (RW)
  ) uOctGen (
    .xc_i       (xc_q),
    .yc_i       (yc_q),
    .cx_i       (cxNext_d),
    .cy_i       (cyNext_d),
    .octant_i   (octNext_d),
    .px_o       (pxGen),
    .py_o       (pyGen),
    .onScreen_o (onScreenGen)
  );

  // Plotter FSM with registered outputs. During CLEAR the scan position lives
  // directly in the x/y output registers.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q       <= IDLE;
      xc_q          <= '0;
      yc_q          <= '0;
      radius_q      <= '0;
      colourLatch_q <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      d_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      colourOut_q   <= '0;
      plot_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.clear) begin
              state_q     <= CLEAR;
              x_q         <= '0;
              y_q         <= '0;
              colourOut_q <= CW'(CLEAR_COLOUR);
              plot_q      <= 1'b1;
            end else begin
              state_q       <= INIT;
              xc_q          <= bus.xc;
              yc_q          <= bus.yc;
              radius_q      <= bus.radius;
              colourLatch_q <= bus.colour_in;
            end
          end
        end
        CLEAR: begin
          if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
            state_q <= DONE;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        INIT, UPDATE: begin
          cx_q <= cxNext_d;
          cy_q <= cyNext_d;
          d_q  <= dNext_d;
          if ((state_q == INIT) ? (cyNext_d >= cxNext_d) : loopAgain_d) begin
            state_q     <= OCT0;
            x_q         <= pxGen[XW-1:0];
            y_q         <= pyGen[YW-1:0];
            colourOut_q <= colourLatch_q;
            plot_q      <= onScreenGen;
          end else begin
            state_q <= DONE;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        OCT0, OCT1, OCT2, OCT3, OCT4, OCT5, OCT6: begin
          state_q     <= state_t'(4'(state_q) + 4'd1);
          x_q         <= pxGen[XW-1:0];
          y_q         <= pyGen[YW-1:0];
          colourOut_q <= colourLatch_q;
          plot_q      <= onScreenGen;
        end
        OCT7: begin
          state_q <= UPDATE;
          plot_q  <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/circle_plotter.md
Name: circle_plotter

Overview:
- Parametrised midpoint (Bresenham) circle rasteriser that drives the pixel-write port (x, y, colour, plot) of the VGA frame-buffer adapter.
- Successor to the fixed 160x120 circle drawer. Adds:
  - runtime centre, radius and colour;
  - start/busy/done handshake;
  - a full-screen clear mode;
  - per-pixel off-screen clipping.
- Sits between switch/key decode logic and vga_adapter. Emits at most one pixel per clock.

Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- XW, 8, x coordinate width (must satisfy 2^XW >= SCREEN_W)
- YW, 7, y coordinate width (must satisfy 2^YW >= SCREEN_H)
- CW, 3, colour width
- RW, 7, radius width
- CLEAR_COLOUR, 0, colour written in clear mode

Ports:
- CLOCK_50  in  1  system clock, rising edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- clear  in  1  mode select, sampled with start: 1 = clear screen, 0 = draw circle
- xc  in  XW  circle centre x, unsigned
- yc  in  YW  circle centre y, unsigned
- radius  in  RW  circle radius, unsigned
- colour_in  in  CW  circle colour
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse when the operation completes
- x  out  XW  pixel x to adapter
- y  out  YW  pixel y to adapter
- colour  out  CW  pixel colour to adapter
- plot  out  1  pixel write enable; all outputs are registered

Behaviour:
- Reset (resetn=0 at a clock edge, any state, including mid-draw or mid-clear):
  - state goes to IDLE;
  - x=0, y=0, colour=0, plot=0, busy=0, done=0;
  - internal cx, cy, d cleared;
  - no partial pixel is emitted afterwards.
- IDLE: plot=0.
  - start=1 with clear=1 goes to CLEAR.
  - start=1 with clear=0 latches xc, yc, radius and colour_in, then goes to INIT.
  - No effect while busy.
- CLEAR: raster scan, one pixel per cycle, with plot=1 and colour=CLEAR_COLOUR.
  - x increments 0..SCREEN_W-1; on wrap, x returns to 0 and y increments.
  - The pixel at (SCREEN_W-1, SCREEN_H-1) is the last one written; then go to DONE.
  - Total: exactly SCREEN_W*SCREEN_H plot cycles.
- INIT (1 cycle, plot=0): cx=0, cy=r, d=3-2r.
  - d is signed, RW+4 bits wide; all arithmetic is sign-extended to that width.
  - If cy < cx, go to DONE; otherwise go to OCT0.
- OCT0..OCT7: one octant point per cycle, in this fixed order:
  - (xc+cx, yc+cy), (xc-cx, yc+cy), (xc+cx, yc-cy), (xc-cx, yc-cy)
  - (xc+cy, yc+cx), (xc-cy, yc+cx), (xc+cy, yc-cx), (xc-cy, yc-cx)
  - Sums are formed as signed values, XW+2 and YW+2 bits wide.
  - plot=1 only if 0<=px<SCREEN_W and 0<=py<SCREEN_H. Otherwise plot=0, and x, y are don't-care.
  - A clipped point still consumes its cycle.
  - Duplicate points (cx=0 or cx=cy) are re-emitted; no de-duplication.
- UPDATE (1 cycle, plot=0), using the pre-increment cx and cy:
  - if d<0: d += 4*cx+6;
  - else: d += 4*(cx-cy)+10 and cy -= 1;
  - cx += 1 in both cases.
  - Then loop to OCT0 if cy >= cx (new values); otherwise go to DONE.
- Per-step cost is 9 cycles. Latency from start to first pixel is 2 cycles (accept, INIT).
- DONE (1 cycle): done=1, busy=0, plot=0, then go to IDLE.
  - start held high re-triggers on the next IDLE cycle.
- Changing xc, yc, radius or colour_in during busy has no effect, because the values are latched.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CLEAR, INIT, OCT0-7, UPDATE, DONE);
  - the default screen constants 160/120;
  - a clip-check function.
- One sub-module is natural: circle_octant_gen, combinational. It maps (xc, yc, cx, cy, octant index) to (px, py, on_screen).
- Top file holds the FSM, the decision variable, and the clear scan.

Test Plan:
- Draw: xc=80, yc=60, r=3.
  - Expect 3 steps: (cx,cy) = (0,3), (1,3), (2,2); d sequence -3, 3, 5, 15.
  - Expect 24 plot cycles, the first being (80,63), then done.
  - Total busy cycles: 1+3*9 = 28.
- r=0 at (10,10): INIT, then 8 plot cycles all at (10,10), then UPDATE, then done.
- Clipping: xc=2, yc=60, r=5. Every point with xc-cx<0 or xc-cy<0 has plot=0; all others plot=1 with correct coordinates.
- Clear mode: start with clear=1.
  - Exactly 19200 plot=1 cycles, colour=0.
  - Last pixel at (159,119); done asserts the next cycle.
- Reset mid-operation: resetn=0 during OCT3 of an r=20 draw.
  - Next cycle: plot=0, busy=0, x=0, y=0.
  - A new start then draws correctly from INIT.
- Handshake: start pulsed while busy is ignored; busy/done timing matches; a new xc value applied mid-draw does not alter emitted pixels.
